// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-macro signals shared between
// if_stage/mem_stage, the arbiter and the unified memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int BE_W = DATA_W / 8;

  logic              i_if_req_valid;
  logic [ADDR_W-1:0] i_if_req_addr;
  logic              o_if_req_ready;
  logic              i_if_flush;
  logic              o_if_rsp_valid;
  logic [DATA_W-1:0] o_if_rsp_data;

  logic              i_dm_req_valid;
  logic              i_dm_req_we;
  logic [BE_W-1:0]   i_dm_req_be;
  logic [ADDR_W-1:0] i_dm_req_addr;
  logic [DATA_W-1:0] i_dm_req_wdata;
  logic              o_dm_req_ready;
  logic              o_dm_rsp_valid;
  logic [DATA_W-1:0] o_dm_rsp_rdata;

  logic              o_mem_en;
  logic              o_mem_we;
  logic [BE_W-1:0]   o_mem_be;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  logic              o_busy;

  modport slave (
    input  i_if_req_valid, i_if_req_addr, i_if_flush,
    input  i_dm_req_valid, i_dm_req_we, i_dm_req_be,
    input  i_dm_req_addr, i_dm_req_wdata,
    input  i_mem_rdata,
    output o_if_req_ready, o_if_rsp_valid, o_if_rsp_data,
    output o_dm_req_ready, o_dm_rsp_valid, o_dm_rsp_rdata,
    output o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    output o_busy
  );

  modport master (
    output i_if_req_valid, i_if_req_addr, i_if_flush,
    output i_dm_req_valid, i_dm_req_we, i_dm_req_be,
    output i_dm_req_addr, i_dm_req_wdata,
    output i_mem_rdata,
    input  o_if_req_ready, o_if_rsp_valid, o_if_rsp_data,
    input  o_dm_req_ready, o_dm_rsp_valid, o_dm_rsp_rdata,
    input  o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
    input  o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction
// fetch and the data port; stale fetch responses are dropped.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  lat_q;
  logic [SC_W-1:0]   starve_q;
  logic              drop_q;

  logic              if_rsp_valid_q;
  logic [DATA_W-1:0] if_rsp_data_q;
  logic              dm_rsp_valid_q;
  logic [DATA_W-1:0] dm_rsp_rdata_q;

  logic if_win;
  logic if_grant;
  logic dm_grant;
  logic capture;
  logic flush_hit;
  logic mem_en;

  // owner_q: 0 = instruction fetch, 1 = data port
  assign if_win = bus.i_if_req_valid && !bus.i_if_flush &&
                  (!bus.i_dm_req_valid || starve_q == STARVE_TOP);

  always_comb begin
    state_d  = state_q;
    if_grant = 1'b0;
    dm_grant = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst) begin
          if_grant = if_win;
          dm_grant = bus.i_dm_req_valid && !if_win;
        end
        if (if_grant || dm_grant) state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (lat_q == '0) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_hit = bus.i_if_flush && !owner_q && state_q != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      be_q           <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      lat_q          <= '0;
      starve_q       <= '0;
      drop_q         <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      dm_rsp_valid_q <= 1'b0;
      dm_rsp_rdata_q <= '0;
    end else begin
      state_q        <= state_d;
      if_rsp_valid_q <= 1'b0;
      dm_rsp_valid_q <= 1'b0;

      if (if_grant) begin
        owner_q <= 1'b0;
        we_q    <= 1'b0;
        be_q    <= '0;
        addr_q  <= bus.i_if_req_addr;
        wdata_q <= '0;
      end else if (dm_grant) begin
        owner_q <= 1'b1;
        we_q    <= bus.i_dm_req_we;
        be_q    <= bus.i_dm_req_be;
        addr_q  <= bus.i_dm_req_addr;
        wdata_q <= bus.i_dm_req_wdata;
      end

      if (state_q == ISSUE) lat_q <= LAT_LOAD;
      else if (state_q == WAIT && lat_q != '0) lat_q <= lat_q - 1'b1;

      if (if_grant) begin
        starve_q <= '0;
      end else if (dm_grant && bus.i_if_req_valid) begin
        if (starve_q != STARVE_TOP) starve_q <= starve_q + 1'b1;
      end else if (state_q == IDLE && !bus.i_if_req_valid) begin
        starve_q <= '0;
      end

      // A redirect landing on the final wait cycle still kills the pulse
      if (capture) drop_q <= 1'b0;
      else if (flush_hit) drop_q <= 1'b1;

      if (capture) begin
        if (owner_q) begin
          dm_rsp_valid_q <= 1'b1;
          dm_rsp_rdata_q <= we_q ? '0 : bus.i_mem_rdata;
        end else begin
          if_rsp_data_q  <= bus.i_mem_rdata;
          if_rsp_valid_q <= !(drop_q || flush_hit);
        end
      end
    end
  end

  assign mem_en = (state_q == ISSUE);

  assign bus.o_if_req_ready = if_grant;
  assign bus.o_dm_req_ready = dm_grant;
  assign bus.o_if_rsp_valid = if_rsp_valid_q;
  assign bus.o_if_rsp_data  = if_rsp_data_q;
  assign bus.o_dm_rsp_valid = dm_rsp_valid_q;
  assign bus.o_dm_rsp_rdata = dm_rsp_rdata_q;
  assign bus.o_mem_en       = mem_en;
  assign bus.o_mem_we       = mem_en ? we_q : 1'b0;
  assign bus.o_mem_be       = mem_en ? be_q : '0;
  assign bus.o_mem_addr     = mem_en ? addr_q : '0;
  assign bus.o_mem_wdata    = mem_en ? wdata_q : '0;
  assign bus.o_busy         = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; memory model returns addr + 1
// exactly two cycles after the access strobe.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] p1 = '0;
  logic [63:0] p2 = '0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) begin
    p1 <= bus.o_mem_en ? bus.o_mem_addr + 64'd1 : 64'd0;
    p2 <= p1;
  end
  assign bus.i_mem_rdata = p2;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_if_req_valid = 0;
    bus.i_if_req_addr  = '0;
    bus.i_if_flush     = 0;
    bus.i_dm_req_valid = 0;
    bus.i_dm_req_we    = 0;
    bus.i_dm_req_be    = '0;
    bus.i_dm_req_addr  = '0;
    bus.i_dm_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    smp();
    chk("rst_en", 64'(bus.o_mem_en), 0);
    chk("rst_busy", 64'(bus.o_busy), 0);
    chk("rst_if_rsp", 64'(bus.o_if_rsp_valid), 0);
    chk("rst_dm_rsp", 64'(bus.o_dm_rsp_valid), 0);
    chk("rst_if_data", bus.o_if_rsp_data, 0);
    chk("rst_dm_data", bus.o_dm_rsp_rdata, 0);

    // 1: single fetch
    nxt();
    bus.i_if_req_valid = 1;
    bus.i_if_req_addr  = 64'h100;
    smp();
    chk("t1_if_ready", 64'(bus.o_if_req_ready), 1);
    chk("t1_dm_ready", 64'(bus.o_dm_req_ready), 0);
    chk("t1_busy0", 64'(bus.o_busy), 0);
    nxt();
    bus.i_if_req_valid = 0;
    bus.i_if_req_addr  = 64'hFFF;
    smp();
    chk("t1_en", 64'(bus.o_mem_en), 1);
    chk("t1_addr", bus.o_mem_addr, 64'h100);
    chk("t1_we", 64'(bus.o_mem_we), 0);
    chk("t1_be", 64'(bus.o_mem_be), 0);
    chk("t1_busy1", 64'(bus.o_busy), 1);
    nxt();
    smp();
    chk("t1_busy2", 64'(bus.o_busy), 1);
    chk("t1_en2", 64'(bus.o_mem_en), 0);
    chk("t1_addr2", bus.o_mem_addr, 0);
    nxt();
    smp();
    chk("t1_busy3", 64'(bus.o_busy), 1);
    chk("t1_rsp3", 64'(bus.o_if_rsp_valid), 0);
    nxt();
    smp();
    chk("t1_rsp4", 64'(bus.o_if_rsp_valid), 1);
    chk("t1_data4", bus.o_if_rsp_data, 64'h101);
    chk("t1_busy4", 64'(bus.o_busy), 0);
    nxt();
    smp();
    chk("t1_rsp5", 64'(bus.o_if_rsp_valid), 0);
    chk("t1_hold5", bus.o_if_rsp_data, 64'h101);

    // 2: data wins a tie, fetch follows
    nxt();
    bus.i_if_req_valid = 1;
    bus.i_if_req_addr  = 64'h300;
    bus.i_dm_req_valid = 1;
    bus.i_dm_req_we    = 0;
    bus.i_dm_req_addr  = 64'h200;
    smp();
    chk("t2_dm_ready0", 64'(bus.o_dm_req_ready), 1);
    chk("t2_if_ready0", 64'(bus.o_if_req_ready), 0);
    nxt();
    bus.i_dm_req_valid = 0;
    smp();
    chk("t2_addr1", bus.o_mem_addr, 64'h200);
    chk("t2_if_ready1", 64'(bus.o_if_req_ready), 0);
    nxt(3);
    smp();
    chk("t2_dm_rsp4", 64'(bus.o_dm_rsp_valid), 1);
    chk("t2_dm_data4", bus.o_dm_rsp_rdata, 64'h201);
    chk("t2_if_ready4", 64'(bus.o_if_req_ready), 1);
    nxt();
    bus.i_if_req_valid = 0;
    smp();
    chk("t2_addr5", bus.o_mem_addr, 64'h300);
    chk("t2_dm_rsp5", 64'(bus.o_dm_rsp_valid), 0);
    nxt(3);
    smp();
    chk("t2_if_rsp8", 64'(bus.o_if_rsp_valid), 1);
    chk("t2_if_data8", bus.o_if_rsp_data, 64'h301);

    // 3: starvation forces fetch after two data grants
    nxt();
    bus.i_if_req_valid = 1;
    bus.i_if_req_addr  = 64'h500;
    bus.i_dm_req_valid = 1;
    bus.i_dm_req_addr  = 64'h400;
    smp();
    chk("t3_dm_ready0", 64'(bus.o_dm_req_ready), 1);
    nxt(4);
    smp();
    chk("t3_dm_ready4", 64'(bus.o_dm_req_ready), 1);
    chk("t3_if_ready4", 64'(bus.o_if_req_ready), 0);
    chk("t3_dm_data4", bus.o_dm_rsp_rdata, 64'h401);
    nxt(4);
    smp();
    chk("t3_if_ready8", 64'(bus.o_if_req_ready), 1);
    chk("t3_dm_ready8", 64'(bus.o_dm_req_ready), 0);
    nxt();
    smp();
    chk("t3_starve9", 64'(dut.starve_q), 0);
    chk("t3_addr9", bus.o_mem_addr, 64'h500);
    nxt(3);
    smp();
    chk("t3_dm_ready12", 64'(bus.o_dm_req_ready), 1);
    chk("t3_if_rsp12", 64'(bus.o_if_rsp_valid), 1);
    chk("t3_if_data12", bus.o_if_rsp_data, 64'h501);
    nxt();
    bus.i_if_req_valid = 0;
    bus.i_dm_req_valid = 0;
    nxt(3);
    smp();
    chk("t3_dm_rsp16", 64'(bus.o_dm_rsp_valid), 1);

    // 4: store
    nxt();
    bus.i_dm_req_valid = 1;
    bus.i_dm_req_we    = 1;
    bus.i_dm_req_be    = 8'h0F;
    bus.i_dm_req_addr  = 64'h40;
    bus.i_dm_req_wdata = 64'hDEAD;
    smp();
    chk("t4_ready0", 64'(bus.o_dm_req_ready), 1);
    nxt();
    bus.i_dm_req_valid = 0;
    bus.i_dm_req_we    = 0;
    bus.i_dm_req_be    = '0;
    bus.i_dm_req_wdata = '0;
    smp();
    chk("t4_en1", 64'(bus.o_mem_en), 1);
    chk("t4_we1", 64'(bus.o_mem_we), 1);
    chk("t4_be1", 64'(bus.o_mem_be), 64'h0F);
    chk("t4_wdata1", bus.o_mem_wdata, 64'hDEAD);
    chk("t4_addr1", bus.o_mem_addr, 64'h40);
    nxt(3);
    smp();
    chk("t4_rsp4", 64'(bus.o_dm_rsp_valid), 1);
    chk("t4_rdata4", bus.o_dm_rsp_rdata, 0);

    // 5: redirect drops the in-flight fetch
    nxt();
    bus.i_if_req_valid = 1;
    bus.i_if_req_addr  = 64'h600;
    smp();
    chk("t5_ready0", 64'(bus.o_if_req_ready), 1);
    nxt();
    bus.i_if_req_valid = 0;
    smp();
    chk("t5_en1", 64'(bus.o_mem_en), 1);
    chk("t5_addr1", bus.o_mem_addr, 64'h600);
    nxt();
    bus.i_if_flush = 1;
    smp();
    chk("t5_ready2", 64'(bus.o_if_req_ready), 0);
    nxt();
    bus.i_if_flush = 0;
    nxt();
    bus.i_if_req_valid = 1;
    bus.i_if_req_addr  = 64'h700;
    smp();
    chk("t5_rsp4", 64'(bus.o_if_rsp_valid), 0);
    chk("t5_ready4", 64'(bus.o_if_req_ready), 1);
    nxt();
    bus.i_if_req_valid = 0;
    nxt(3);
    smp();
    chk("t5_rsp8", 64'(bus.o_if_rsp_valid), 1);
    chk("t5_data8", bus.o_if_rsp_data, 64'h701);

    // 6: reset mid-access
    nxt();
    bus.i_dm_req_valid = 1;
    bus.i_dm_req_we    = 0;
    bus.i_dm_req_addr  = 64'h800;
    smp();
    chk("t6_ready0", 64'(bus.o_dm_req_ready), 1);
    nxt();
    bus.i_dm_req_valid = 0;
    nxt();
    rst = 1;
    smp();
    chk("t6_ready_rst", 64'(bus.o_dm_req_ready), 0);
    nxt();
    rst = 0;
    bus.i_dm_req_valid = 1;
    bus.i_dm_req_addr  = 64'h900;
    smp();
    chk("t6_busy3", 64'(bus.o_busy), 0);
    chk("t6_en3", 64'(bus.o_mem_en), 0);
    chk("t6_rsp3", 64'(bus.o_dm_rsp_valid), 0);
    chk("t6_data3", bus.o_dm_rsp_rdata, 0);
    chk("t6_state3", 64'(dut.state_q), 0);
    chk("t6_ready3", 64'(bus.o_dm_req_ready), 1);
    nxt();
    bus.i_dm_req_valid = 0;
    smp();
    chk("t6_rsp4", 64'(bus.o_dm_rsp_valid), 0);
    chk("t6_addr4", bus.o_mem_addr, 64'h900);
    nxt(3);
    smp();
    chk("t6_rsp7", 64'(bus.o_dm_rsp_valid), 1);
    chk("t6_data7", bus.o_dm_rsp_rdata, 64'h901);

    // 7: flush in idle only blocks that cycle
    nxt();
    bus.i_if_req_valid = 1;
    bus.i_if_req_addr  = 64'hA00;
    bus.i_if_flush     = 1;
    smp();
    chk("t7_blocked", 64'(bus.o_if_req_ready), 0);
    nxt();
    bus.i_if_flush = 0;
    smp();
    chk("t7_granted", 64'(bus.o_if_req_ready), 1);
    nxt();
    bus.i_if_req_valid = 0;
    nxt(3);
    smp();
    chk("t7_rsp", 64'(bus.o_if_rsp_valid), 1);
    chk("t7_data", bus.o_if_rsp_data, 64'hA01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
